ulm_instr_decode: RTL and testbench
===================================

// Module: ulm_instr_decode
// PURPOSE
//   Registered instruction decoder for the ULM CPU.
//   - Splits the 32-bit instruction register into three control bundles: ALU, bus and CU.
//   - CU covers jumps and halt.
//   - Sits between the instruction register / fetch stage and the execute units
//     (ALU, bus/RAM port, control unit).
//   - Conditional jumps are resolved at decode time from the ALU zero and carry flags.
// PARAMETERS
//   none (widths fixed by the ULM ISA)
// PORTS
//   clk            in   1   clock; all state updates on rising edge
//   rst            in   1   reset, synchronous, active-high
//   en             in   1   decode strobe; outputs load only when en=1
//   ir             in   32  instruction register; opcode = ir[31:24]
//   zf             in   1   ALU zero flag
//   cf             in   1   ALU carry flag
//   alu_op         out  2   pkg_instr::alu_op_t
//   alu_a_sel      out  1   pkg_instr::alu_sel_t (REG=0, IMM=1)
//   alu_s_reg      out  4   destination register
//   alu_b_reg      out  4   operand-b register
//   alu_a_reg      out  4   operand-a register
//   alu_a_imm      out  64  operand-a immediate
//   bus_op         out  2   pkg_instr::bus_op_t
//   bus_data_type  out  2   pkg_instr::data_type_t
//   bus_data_reg   out  4   data register
//   bus_addr_reg   out  4   address base register
//   bus_addr_offset out 17  signed address displacement
//   cu_op          out  3   pkg_instr::cu_op_t
//   cu_exit_code_imm out 8  halt immediate
//   cu_jmp_offset  out  26  relative jump byte offset
//   cu_reg0        out  4   ir[23:20] (exit-code reg / jump target reg)
//   cu_reg1        out  4   ir[19:16] (return-address reg)
// BEHAVIOUR
//   Reset and enable
//   - rst=1 at a clock edge: every output goes to 0, so all ops are NOP. rst wins over en.
//   - en=1, rst=0: all outputs load the combinational decode of the current ir, zf and cf.
//     Latency is 1 clock.
//   - en=0: all outputs hold their value.
//   Default field slicing (applies to every opcode)
//   - s_reg = ir[23:20], b_reg = ir[19:16], a_reg = ir[15:12].
//   - a_imm = zero-extended ir[15:0].
//   - data_reg = ir[23:20], addr_reg = ir[19:16].
//   - addr_offset = {ir[15], ir[15:0]} (sign-extended).
//   - exit_code_imm = ir[23:16], jmp_offset = {ir[23:0], 2'b00}.
//   - reg0 = ir[23:20], reg1 = ir[19:16].
//   - Default ops: ALU NOP with a_sel=REG, bus NOP with data_type=BYTE, CU NOP.
//   ALU opcodes
//   - 0x10 ldzwq: ADD, IMM, b_reg=0, a_reg=0, a_imm = zero-extended ir[19:0].
//   - 0x11 ADD, REG.
//   - 0x12 ADD, IMM.
//   - 0x13 SUB, REG.
//   - 0x14 SUB, IMM.
//   Bus opcodes
//   - 0x20 FETCH BYTE.
//   - 0x22 STORE BYTE.
//   - 0x23 FETCH QUAD.
//   - 0x24 STORE QUAD.
//   CU opcodes
//   - 0x01 HALT_IMM.
//   - 0x02 HALT_REG.
//   - 0x03 REL_JMP if zf=0, else NOP.
//   - 0x04 REL_JMP if zf=1, else NOP.
//   - 0x05 REL_JMP.
//   - 0x06 REL_JMP if cf=1, else NOP.
//   - 0x07 ABS_JMP.
//   Other rules
//   - Unlisted opcodes (including 0x21 and 0x30-0x32) give NOP on all three bundles.
//   - At most one bundle carries a non-NOP op for any opcode.
//   - zf and cf are sampled in the en cycle only; later flag changes do not alter a held cu_op.
// STRUCTURE
//   - pkg_instr holds:
//     alu_op_t {NOP=0, ADD=1, SUB=2}, alu_sel_t {REG=0, IMM=1},
//     bus_op_t {NOP=0, FETCH=1, STORE=2}, data_type_t {BYTE=0, WORD=1, LONG=2, QUAD=3},
//     cu_op_t {NOP=0, HALT_IMM=1, HALT_REG=2, REL_JMP=3, ABS_JMP=4}, and the opcode constants.
//   - One always_comb block per bundle computes *_next; one always_ff per bundle registers it.
//   - No sub-module is needed.
// TESTING
//   - rst=1 with ir=0x11123000, en=1 -> all ops NOP and all fields 0 after the edge.
//   - ir=0x10301234, en=1 -> alu ADD/IMM, s=3, b=0, a=0, a_imm=0x1234.
//     Same test with ir=0x11123000 -> ADD/REG, s=1, b=2, a=3.
//   - ir=0x04FFFFFF with zf=1 -> cu REL_JMP, jmp_offset=0x3FFFFFC.
//     Same ir with zf=0 -> NOP. ir=0x06000001 with cf=1 -> REL_JMP, offset=4.
//   - ir=0x2354FFF8 -> bus FETCH QUAD, data=5, addr=4, offset=0x1FFF8.
//     ir=0x22210010 -> STORE BYTE, offset=0x00010.
//   - Decode 0x0107xxxx, then en=0 and change ir -> HALT_IMM with exit_code 0x07 held.
//     ir=0x7F000000 -> all NOP.

Source files
------------

// File: rtl/ulm_instr_decode_pkg.sv
// ----------------------------------------------------------------------------
// ulm_instr_decode_pkg
//   Shared ISA definitions for the ULM CPU instruction decoder:
//   - op/selector enums for the ALU, bus and control-unit (CU) bundles
//   - the opcode constants of the ULM ISA
//   - packed structs describing one decoded control bundle each
//   - the all-zero (all-NOP) reset image for every bundle
//   - a small helper that resolves conditional jumps from the ALU flags
// ----------------------------------------------------------------------------
package ulm_instr_decode_pkg;

    // ------------------------------------------------------------------
    // Control enums
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ALU_NOP = 2'd0,
        ALU_ADD = 2'd1,
        ALU_SUB = 2'd2
    } alu_op_t;

    typedef enum logic [0:0] {
        SEL_REG = 1'b0,
        SEL_IMM = 1'b1
    } alu_sel_t;

    typedef enum logic [1:0] {
        BUS_NOP   = 2'd0,
        BUS_FETCH = 2'd1,
        BUS_STORE = 2'd2
    } bus_op_t;

    typedef enum logic [1:0] {
        DT_BYTE = 2'd0,
        DT_WORD = 2'd1,
        DT_LONG = 2'd2,
        DT_QUAD = 2'd3
    } data_type_t;

    typedef enum logic [2:0] {
        CU_NOP      = 3'd0,
        CU_HALT_IMM = 3'd1,
        CU_HALT_REG = 3'd2,
        CU_REL_JMP  = 3'd3,
        CU_ABS_JMP  = 3'd4
    } cu_op_t;

    // ------------------------------------------------------------------
    // Opcodes (ir[31:24])
    // ------------------------------------------------------------------
    localparam logic [7:0] OP_HALT_IMM  = 8'h01;
    localparam logic [7:0] OP_HALT_REG  = 8'h02;
    localparam logic [7:0] OP_JNZ       = 8'h03;
    localparam logic [7:0] OP_JZ        = 8'h04;
    localparam logic [7:0] OP_JMP       = 8'h05;
    localparam logic [7:0] OP_JC        = 8'h06;
    localparam logic [7:0] OP_JMP_ABS   = 8'h07;
    localparam logic [7:0] OP_LDZWQ     = 8'h10;
    localparam logic [7:0] OP_ADD_REG   = 8'h11;
    localparam logic [7:0] OP_ADD_IMM   = 8'h12;
    localparam logic [7:0] OP_SUB_REG   = 8'h13;
    localparam logic [7:0] OP_SUB_IMM   = 8'h14;
    localparam logic [7:0] OP_FETCH_B   = 8'h20;
    localparam logic [7:0] OP_STORE_B   = 8'h22;
    localparam logic [7:0] OP_FETCH_Q   = 8'h23;
    localparam logic [7:0] OP_STORE_Q   = 8'h24;

    // ------------------------------------------------------------------
    // Decoded bundles
    // ------------------------------------------------------------------
    typedef struct packed {
        alu_op_t     op;
        alu_sel_t    a_sel;
        logic [3:0]  s_reg;
        logic [3:0]  b_reg;
        logic [3:0]  a_reg;
        logic [63:0] a_imm;
    } alu_ctrl_t;

    typedef struct packed {
        bus_op_t     op;
        data_type_t  data_type;
        logic [3:0]  data_reg;
        logic [3:0]  addr_reg;
        logic [16:0] addr_offset;
    } bus_ctrl_t;

    typedef struct packed {
        cu_op_t      op;
        logic [7:0]  exit_code_imm;
        logic [25:0] jmp_offset;
        logic [3:0]  reg0;
        logic [3:0]  reg1;
    } cu_ctrl_t;

    // Reset images: every field zero, which encodes NOP on every bundle.
    localparam alu_ctrl_t ALU_CTRL_RESET = '{
        op:    ALU_NOP,
        a_sel: SEL_REG,
        s_reg: 4'd0,
        b_reg: 4'd0,
        a_reg: 4'd0,
        a_imm: 64'd0
    };

    localparam bus_ctrl_t BUS_CTRL_RESET = '{
        op:          BUS_NOP,
        data_type:   DT_BYTE,
        data_reg:    4'd0,
        addr_reg:    4'd0,
        addr_offset: 17'd0
    };

    localparam cu_ctrl_t CU_CTRL_RESET = '{
        op:            CU_NOP,
        exit_code_imm: 8'd0,
        jmp_offset:    26'd0,
        reg0:          4'd0,
        reg1:          4'd0
    };

    // ------------------------------------------------------------------
    // Conditional-jump resolution: returns REL_JMP when the condition
    // encoded by the opcode holds for the given flags, NOP otherwise.
    // Only called for the four relative-jump opcodes.
    // ------------------------------------------------------------------
    function automatic cu_op_t resolve_rel_jmp(
        input logic [7:0] opcode,
        input logic       zf,
        input logic       cf
    );
        logic taken;
        case (opcode)
            OP_JNZ:  taken = ~zf;
            OP_JZ:   taken = zf;
            OP_JMP:  taken = 1'b1;
            OP_JC:   taken = cf;
            default: taken = 1'b0;
        endcase
        resolve_rel_jmp = taken ? CU_REL_JMP : CU_NOP;
    endfunction

endpackage : ulm_instr_decode_pkg

// File: rtl/ulm_instr_decode.sv
// ----------------------------------------------------------------------------
// ulm_instr_decode
//   Registered instruction decoder for the ULM CPU. Splits the 32-bit
//   instruction register into ALU, bus and control-unit bundles. Conditional
//   jumps are resolved here from the ALU zero/carry flags sampled in the
//   decode-strobe cycle. All outputs are flops with a 1-clock latency.
//
// Ports
//   clk               in   1   clock, rising edge
//   rst               in   1   synchronous active-high reset (wins over en)
//   en                in   1   decode strobe; outputs load only when en=1
//   ir                in   32  instruction register, opcode = ir[31:24]
//   zf, cf            in   1   ALU zero / carry flags
//   alu_op            out  2   alu_op_t
//   alu_a_sel         out  1   alu_sel_t (REG=0, IMM=1)
//   alu_s_reg         out  4   destination register
//   alu_b_reg         out  4   operand-b register
//   alu_a_reg         out  4   operand-a register
//   alu_a_imm         out  64  operand-a immediate
//   bus_op            out  2   bus_op_t
//   bus_data_type     out  2   data_type_t
//   bus_data_reg      out  4   data register
//   bus_addr_reg      out  4   address base register
//   bus_addr_offset   out  17  signed address displacement
//   cu_op             out  3   cu_op_t
//   cu_exit_code_imm  out  8   halt immediate
//   cu_jmp_offset     out  26  relative jump byte offset
//   cu_reg0           out  4   ir[23:20]
//   cu_reg1           out  4   ir[19:16]
// ----------------------------------------------------------------------------
module ulm_instr_decode
    import ulm_instr_decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] ir,
    input  logic        zf,
    input  logic        cf,

    output logic [1:0]  alu_op,
    output logic        alu_a_sel,
    output logic [3:0]  alu_s_reg,
    output logic [3:0]  alu_b_reg,
    output logic [3:0]  alu_a_reg,
    output logic [63:0] alu_a_imm,

    output logic [1:0]  bus_op,
    output logic [1:0]  bus_data_type,
    output logic [3:0]  bus_data_reg,
    output logic [3:0]  bus_addr_reg,
    output logic [16:0] bus_addr_offset,

    output logic [2:0]  cu_op,
    output logic [7:0]  cu_exit_code_imm,
    output logic [25:0] cu_jmp_offset,
    output logic [3:0]  cu_reg0,
    output logic [3:0]  cu_reg1
);

    logic [7:0] opcode_s;
    alu_ctrl_t  alu_next_s;
    bus_ctrl_t  bus_next_s;
    cu_ctrl_t   cu_next_s;
    alu_ctrl_t  alu_r;
    bus_ctrl_t  bus_r;
    cu_ctrl_t   cu_r;

    assign opcode_s = ir[31:24];

    // ALU bundle: default field slicing, then opcode-specific op/select.
    always_comb begin
        alu_next_s.op    = ALU_NOP;
        alu_next_s.a_sel = SEL_REG;
        alu_next_s.s_reg = ir[23:20];
        alu_next_s.b_reg = ir[19:16];
        alu_next_s.a_reg = ir[15:12];
        alu_next_s.a_imm = {48'd0, ir[15:0]};
        case (opcode_s)
            OP_LDZWQ: begin
                // ldzwq borrows the b_reg nibble as immediate bits 19:16,
                // so both register operands are forced to r0.
                alu_next_s.op    = ALU_ADD;
                alu_next_s.a_sel = SEL_IMM;
                alu_next_s.b_reg = 4'd0;
                alu_next_s.a_reg = 4'd0;
                alu_next_s.a_imm = {44'd0, ir[19:0]};
            end
            OP_ADD_REG: begin
                alu_next_s.op    = ALU_ADD;
                alu_next_s.a_sel = SEL_REG;
            end
            OP_ADD_IMM: begin
                alu_next_s.op    = ALU_ADD;
                alu_next_s.a_sel = SEL_IMM;
            end
            OP_SUB_REG: begin
                alu_next_s.op    = ALU_SUB;
                alu_next_s.a_sel = SEL_REG;
            end
            OP_SUB_IMM: begin
                alu_next_s.op    = ALU_SUB;
                alu_next_s.a_sel = SEL_IMM;
            end
            default: begin
                alu_next_s.op    = ALU_NOP;
                alu_next_s.a_sel = SEL_REG;
            end
        endcase
    end

    // Bus bundle: default field slicing, then opcode-specific op/data type.
    always_comb begin
        bus_next_s.op          = BUS_NOP;
        bus_next_s.data_type   = DT_BYTE;
        bus_next_s.data_reg    = ir[23:20];
        bus_next_s.addr_reg    = ir[19:16];
        bus_next_s.addr_offset = {ir[15], ir[15:0]};
        case (opcode_s)
            OP_FETCH_B: begin
                bus_next_s.op        = BUS_FETCH;
                bus_next_s.data_type = DT_BYTE;
            end
            OP_STORE_B: begin
                bus_next_s.op        = BUS_STORE;
                bus_next_s.data_type = DT_BYTE;
            end
            OP_FETCH_Q: begin
                bus_next_s.op        = BUS_FETCH;
                bus_next_s.data_type = DT_QUAD;
            end
            OP_STORE_Q: begin
                bus_next_s.op        = BUS_STORE;
                bus_next_s.data_type = DT_QUAD;
            end
            default: begin
                bus_next_s.op        = BUS_NOP;
                bus_next_s.data_type = DT_BYTE;
            end
        endcase
    end

    // CU bundle: default field slicing, then halt / jump op with the
    // conditional jumps resolved from the current flags.
    always_comb begin
        cu_next_s.op            = CU_NOP;
        cu_next_s.exit_code_imm = ir[23:16];
        cu_next_s.jmp_offset    = {ir[23:0], 2'b00};
        cu_next_s.reg0          = ir[23:20];
        cu_next_s.reg1          = ir[19:16];
        case (opcode_s)
            OP_HALT_IMM: cu_next_s.op = CU_HALT_IMM;
            OP_HALT_REG: cu_next_s.op = CU_HALT_REG;
            OP_JNZ,
            OP_JZ,
            OP_JMP,
            OP_JC:       cu_next_s.op = resolve_rel_jmp(opcode_s, zf, cf);
            OP_JMP_ABS:  cu_next_s.op = CU_ABS_JMP;
            default:     cu_next_s.op = CU_NOP;
        endcase
    end

    // ALU bundle register: reset to NOP, load on en, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_r <= ALU_CTRL_RESET;
        end else if (en) begin
            alu_r <= alu_next_s;
        end else begin
            alu_r <= alu_r;
        end
    end

    // Bus bundle register: reset to NOP, load on en, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_r <= BUS_CTRL_RESET;
        end else if (en) begin
            bus_r <= bus_next_s;
        end else begin
            bus_r <= bus_r;
        end
    end

    // CU bundle register: flags are captured only through this load, so a
    // held jump decision is immune to later flag changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cu_r <= CU_CTRL_RESET;
        end else if (en) begin
            cu_r <= cu_next_s;
        end else begin
            cu_r <= cu_r;
        end
    end

    assign alu_op           = alu_r.op;
    assign alu_a_sel        = alu_r.a_sel;
    assign alu_s_reg        = alu_r.s_reg;
    assign alu_b_reg        = alu_r.b_reg;
    assign alu_a_reg        = alu_r.a_reg;
    assign alu_a_imm        = alu_r.a_imm;

    assign bus_op           = bus_r.op;
    assign bus_data_type    = bus_r.data_type;
    assign bus_data_reg     = bus_r.data_reg;
    assign bus_addr_reg     = bus_r.addr_reg;
    assign bus_addr_offset  = bus_r.addr_offset;

    assign cu_op            = cu_r.op;
    assign cu_exit_code_imm = cu_r.exit_code_imm;
    assign cu_jmp_offset    = cu_r.jmp_offset;
    assign cu_reg0          = cu_r.reg0;
    assign cu_reg1          = cu_r.reg1;

endmodule : ulm_instr_decode

// File: tb/tb_ulm_instr_decode.sv
// ----------------------------------------------------------------------------
// tb_ulm_instr_decode
//   Directed self-checking bench for ulm_instr_decode. Each task drives one
//   scenario and compares the registered outputs against hand-computed values.
// ----------------------------------------------------------------------------
module tb_ulm_instr_decode;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] ir;
    logic        zf;
    logic        cf;

    logic [1:0]  alu_op;
    logic        alu_a_sel;
    logic [3:0]  alu_s_reg;
    logic [3:0]  alu_b_reg;
    logic [3:0]  alu_a_reg;
    logic [63:0] alu_a_imm;
    logic [1:0]  bus_op;
    logic [1:0]  bus_data_type;
    logic [3:0]  bus_data_reg;
    logic [3:0]  bus_addr_reg;
    logic [16:0] bus_addr_offset;
    logic [2:0]  cu_op;
    logic [7:0]  cu_exit_code_imm;
    logic [25:0] cu_jmp_offset;
    logic [3:0]  cu_reg0;
    logic [3:0]  cu_reg1;

    int checks;
    int failures;

    ulm_instr_decode dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .ir               (ir),
        .zf               (zf),
        .cf               (cf),
        .alu_op           (alu_op),
        .alu_a_sel        (alu_a_sel),
        .alu_s_reg        (alu_s_reg),
        .alu_b_reg        (alu_b_reg),
        .alu_a_reg        (alu_a_reg),
        .alu_a_imm        (alu_a_imm),
        .bus_op           (bus_op),
        .bus_data_type    (bus_data_type),
        .bus_data_reg     (bus_data_reg),
        .bus_addr_reg     (bus_addr_reg),
        .bus_addr_offset  (bus_addr_offset),
        .cu_op            (cu_op),
        .cu_exit_code_imm (cu_exit_code_imm),
        .cu_jmp_offset    (cu_jmp_offset),
        .cu_reg0          (cu_reg0),
        .cu_reg1          (cu_reg1)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs away from the edge, then sample 1 unit after it.
    task automatic drive(input logic r, input logic e, input logic [31:0] i,
                         input logic z, input logic c);
        @(negedge clk);
        rst = r; en = e; ir = i; zf = z; cf = c;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 32'h1112_3000, 1'b1, 1'b1);
        checks++;
        if ({alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg, alu_a_imm} !== 83'd0) begin
            failures++;
            $display("FAIL reset_alu got=%h exp=0", {alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg, alu_a_imm});
        end
        checks++;
        if ({bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset} !== 29'd0) begin
            failures++;
            $display("FAIL reset_bus got=%h exp=0", {bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset});
        end
        checks++;
        if ({cu_op, cu_exit_code_imm, cu_jmp_offset, cu_reg0, cu_reg1} !== 45'd0) begin
            failures++;
            $display("FAIL reset_cu got=%h exp=0", {cu_op, cu_exit_code_imm, cu_jmp_offset, cu_reg0, cu_reg1});
        end
    endtask

    task automatic test_alu();
        // ldzwq: ADD/IMM, b=a=0, immediate from ir[19:0]
        drive(1'b0, 1'b1, 32'h1030_1234, 1'b0, 1'b0);
        checks++;
        if ({alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg} !== {2'd1, 1'b1, 4'd3, 4'd0, 4'd0}) begin
            failures++;
            $display("FAIL ldzwq_ctrl got=%h exp=%h", {alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg}, {2'd1, 1'b1, 4'd3, 4'd0, 4'd0});
        end
        checks++;
        if (alu_a_imm !== 64'h1234) begin
            failures++;
            $display("FAIL ldzwq_imm got=%h exp=%h", alu_a_imm, 64'h1234);
        end
        checks++;
        if ({bus_op, cu_op} !== 5'd0) begin
            failures++;
            $display("FAIL ldzwq_other_nop got=%h exp=0", {bus_op, cu_op});
        end
        // ldzwq with nonzero ir[19:16]: they feed the immediate, not b_reg
        drive(1'b0, 1'b1, 32'h1035_ABCD, 1'b0, 1'b0);
        checks++;
        if ({alu_b_reg, alu_a_reg, alu_a_imm} !== {4'd0, 4'd0, 64'h5_ABCD}) begin
            failures++;
            $display("FAIL ldzwq_wide got=%h exp=%h", {alu_b_reg, alu_a_reg, alu_a_imm}, {4'd0, 4'd0, 64'h5_ABCD});
        end
        // ADD/REG
        drive(1'b0, 1'b1, 32'h1112_3000, 1'b0, 1'b0);
        checks++;
        if ({alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg} !== {2'd1, 1'b0, 4'd1, 4'd2, 4'd3}) begin
            failures++;
            $display("FAIL add_reg got=%h exp=%h", {alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg}, {2'd1, 1'b0, 4'd1, 4'd2, 4'd3});
        end
        // ADD/IMM: immediate is ir[15:0] zero-extended (no sign extension)
        drive(1'b0, 1'b1, 32'h1245_8001, 1'b0, 1'b0);
        checks++;
        if ({alu_op, alu_a_sel, alu_a_imm} !== {2'd1, 1'b1, 64'h8001}) begin
            failures++;
            $display("FAIL add_imm got=%h exp=%h", {alu_op, alu_a_sel, alu_a_imm}, {2'd1, 1'b1, 64'h8001});
        end
        // SUB/REG and SUB/IMM
        drive(1'b0, 1'b1, 32'h1398_7000, 1'b0, 1'b0);
        checks++;
        if ({alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg} !== {2'd2, 1'b0, 4'd9, 4'd8, 4'd7}) begin
            failures++;
            $display("FAIL sub_reg got=%h exp=%h", {alu_op, alu_a_sel, alu_s_reg, alu_b_reg, alu_a_reg}, {2'd2, 1'b0, 4'd9, 4'd8, 4'd7});
        end
        drive(1'b0, 1'b1, 32'h1421_0005, 1'b0, 1'b0);
        checks++;
        if ({alu_op, alu_a_sel, alu_a_imm} !== {2'd2, 1'b1, 64'h5}) begin
            failures++;
            $display("FAIL sub_imm got=%h exp=%h", {alu_op, alu_a_sel, alu_a_imm}, {2'd2, 1'b1, 64'h5});
        end
    endtask

    task automatic test_bus();
        drive(1'b0, 1'b1, 32'h2354_FFF8, 1'b0, 1'b0);
        checks++;
        if ({bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset} !== {2'd1, 2'd3, 4'd5, 4'd4, 17'h1FFF8}) begin
            failures++;
            $display("FAIL fetch_quad got=%h exp=%h", {bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset}, {2'd1, 2'd3, 4'd5, 4'd4, 17'h1FFF8});
        end
        checks++;
        if ({alu_op, cu_op} !== 5'd0) begin
            failures++;
            $display("FAIL fetch_quad_other_nop got=%h exp=0", {alu_op, cu_op});
        end
        drive(1'b0, 1'b1, 32'h2221_0010, 1'b0, 1'b0);
        checks++;
        if ({bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset} !== {2'd2, 2'd0, 4'd2, 4'd1, 17'h00010}) begin
            failures++;
            $display("FAIL store_byte got=%h exp=%h", {bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset}, {2'd2, 2'd0, 4'd2, 4'd1, 17'h00010});
        end
        drive(1'b0, 1'b1, 32'h2067_7FFF, 1'b0, 1'b0);
        checks++;
        if ({bus_op, bus_data_type, bus_addr_offset} !== {2'd1, 2'd0, 17'h07FFF}) begin
            failures++;
            $display("FAIL fetch_byte got=%h exp=%h", {bus_op, bus_data_type, bus_addr_offset}, {2'd1, 2'd0, 17'h07FFF});
        end
        drive(1'b0, 1'b1, 32'h24AB_8000, 1'b0, 1'b0);
        checks++;
        if ({bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset} !== {2'd2, 2'd3, 4'hA, 4'hB, 17'h18000}) begin
            failures++;
            $display("FAIL store_quad got=%h exp=%h", {bus_op, bus_data_type, bus_data_reg, bus_addr_reg, bus_addr_offset}, {2'd2, 2'd3, 4'hA, 4'hB, 17'h18000});
        end
    endtask

    task automatic test_cu();
        drive(1'b0, 1'b1, 32'h04FF_FFFF, 1'b1, 1'b0);
        checks++;
        if ({cu_op, cu_jmp_offset} !== {3'd3, 26'h3FF_FFFC}) begin
            failures++;
            $display("FAIL jz_taken got=%h exp=%h", {cu_op, cu_jmp_offset}, {3'd3, 26'h3FF_FFFC});
        end
        drive(1'b0, 1'b1, 32'h04FF_FFFF, 1'b0, 1'b0);
        checks++;
        if ({cu_op, cu_jmp_offset} !== {3'd0, 26'h3FF_FFFC}) begin
            failures++;
            $display("FAIL jz_not_taken got=%h exp=%h", {cu_op, cu_jmp_offset}, {3'd0, 26'h3FF_FFFC});
        end
        drive(1'b0, 1'b1, 32'h0600_0001, 1'b0, 1'b1);
        checks++;
        if ({cu_op, cu_jmp_offset} !== {3'd3, 26'd4}) begin
            failures++;
            $display("FAIL jc_taken got=%h exp=%h", {cu_op, cu_jmp_offset}, {3'd3, 26'd4});
        end
        drive(1'b0, 1'b1, 32'h0600_0001, 1'b1, 1'b0);
        checks++;
        if (cu_op !== 3'd0) begin
            failures++;
            $display("FAIL jc_not_taken got=%0d exp=0", cu_op);
        end
        drive(1'b0, 1'b1, 32'h0300_0002, 1'b0, 1'b1);
        checks++;
        if (cu_op !== 3'd3) begin
            failures++;
            $display("FAIL jnz_taken got=%0d exp=3", cu_op);
        end
        drive(1'b0, 1'b1, 32'h0300_0002, 1'b1, 1'b0);
        checks++;
        if (cu_op !== 3'd0) begin
            failures++;
            $display("FAIL jnz_not_taken got=%0d exp=0", cu_op);
        end
        drive(1'b0, 1'b1, 32'h0500_0003, 1'b0, 1'b0);
        checks++;
        if ({cu_op, cu_jmp_offset} !== {3'd3, 26'd12}) begin
            failures++;
            $display("FAIL jmp got=%h exp=%h", {cu_op, cu_jmp_offset}, {3'd3, 26'd12});
        end
        drive(1'b0, 1'b1, 32'h07C9_0000, 1'b0, 1'b0);
        checks++;
        if ({cu_op, cu_reg0, cu_reg1} !== {3'd4, 4'hC, 4'h9}) begin
            failures++;
            $display("FAIL abs_jmp got=%h exp=%h", {cu_op, cu_reg0, cu_reg1}, {3'd4, 4'hC, 4'h9});
        end
        drive(1'b0, 1'b1, 32'h0260_0000, 1'b0, 1'b0);
        checks++;
        if ({cu_op, cu_reg0, alu_op, bus_op} !== {3'd2, 4'd6, 2'd0, 2'd0}) begin
            failures++;
            $display("FAIL halt_reg got=%h exp=%h", {cu_op, cu_reg0, alu_op, bus_op}, {3'd2, 4'd6, 2'd0, 2'd0});
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 32'h0107_ABCD, 1'b0, 1'b0);
        checks++;
        if ({cu_op, cu_exit_code_imm} !== {3'd1, 8'h07}) begin
            failures++;
            $display("FAIL halt_imm got=%h exp=%h", {cu_op, cu_exit_code_imm}, {3'd1, 8'h07});
        end
        drive(1'b0, 1'b0, 32'h7F00_0000, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 32'h1112_3000, 1'b0, 1'b0);
        checks++;
        if ({cu_op, cu_exit_code_imm, alu_op} !== {3'd1, 8'h07, 2'd0}) begin
            failures++;
            $display("FAIL halt_imm_hold got=%h exp=%h", {cu_op, cu_exit_code_imm, alu_op}, {3'd1, 8'h07, 2'd0});
        end
        // A taken jump stays taken after zf drops while en is low.
        drive(1'b0, 1'b1, 32'h0400_0010, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 32'h0400_0010, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0400_0010, 1'b0, 1'b0);
        checks++;
        if ({cu_op, cu_jmp_offset} !== {3'd3, 26'h40}) begin
            failures++;
            $display("FAIL flag_hold got=%h exp=%h", {cu_op, cu_jmp_offset}, {3'd3, 26'h40});
        end
    endtask

    task automatic test_unlisted();
        logic [31:0] irs [4];
        irs[0] = 32'h7F00_0000;
        irs[1] = 32'h2154_FFF8;
        irs[2] = 32'h3012_3000;
        irs[3] = 32'h3212_3000;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, irs[k], 1'b1, 1'b1);
            checks++;
            if ({alu_op, alu_a_sel, bus_op, bus_data_type, cu_op} !== 10'd0) begin
                failures++;
                $display("FAIL unlisted_%0d ir=%h got=%h exp=0", k, irs[k], {alu_op, alu_a_sel, bus_op, bus_data_type, cu_op});
            end
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, 32'h1112_3000, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h2354_FFF8, 1'b0, 1'b0);
        checks++;
        if ({alu_op, bus_op, bus_data_type} !== {2'd0, 2'd1, 2'd3}) begin
            failures++;
            $display("FAIL b2b_switch got=%h exp=%h", {alu_op, bus_op, bus_data_type}, {2'd0, 2'd1, 2'd3});
        end
        // rst has priority over en
        drive(1'b1, 1'b1, 32'h0107_0000, 1'b0, 1'b0);
        checks++;
        if ({bus_op, bus_data_reg, bus_addr_offset, cu_op, cu_exit_code_imm} !== 36'd0) begin
            failures++;
            $display("FAIL rst_over_en got=%h exp=0", {bus_op, bus_data_reg, bus_addr_offset, cu_op, cu_exit_code_imm});
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst = 1'b1; en = 1'b0; ir = 32'h0; zf = 1'b0; cf = 1'b0;
        test_reset();
        test_alu();
        test_bus();
        test_cu();
        test_hold();
        test_unlisted();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_ulm_instr_decode
